// File: rtl/traffic_pkg.sv
// Shared constants for the traffic-light controller and its interval timer.
// Holds the default timing values and the one-hot light encodings used by the
// controller and the top level.
package traffic_pkg;

  // Default timer configuration: one clk per tick, 5-tick yellow, 25-tick green.
  localparam int DEF_CNT_W    = 8;
  localparam int DEF_PRESCALE = 1;
  localparam int DEF_TS_TICKS = 5;
  localparam int DEF_TL_TICKS = 25;

  // One-hot light encodings {red, yellow, green}.
  localparam logic [2:0] RED = 3'b100;
  localparam logic [2:0] YEL = 3'b010;
  localparam logic [2:0] GRN = 3'b001;

endpackage

// File: rtl/traffic_timer_tick_gen.sv
// Prescaler for the traffic timer: divides clk into timing ticks.
// pcnt runs 0..PRESCALE-1 while enabled; tick_int is high in the last slot,
// and the counter wraps to 0 on that same edge. clr restarts the count and
// wins over en; rst wins over everything.
module tick_gen
  import traffic_pkg::*;
#(
  parameter int PRESCALE = DEF_PRESCALE
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tick_int
);

  // A single-bit counter is kept even for PRESCALE=1; it simply stays at 0.
  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

  if (PRESCALE < 1) begin : g_bad_prescale
    $error("tick_gen: PRESCALE must be at least 1");
  end

  logic [PW-1:0] pcnt_q;
  logic [PW-1:0] pcnt_d;

  // Tick fires in the last prescaler slot, only while counting is enabled.
  assign tick_int = en && (pcnt_q == LAST);

  // Next prescaler value: clear beats enable, wrap on the tick slot.
  always_comb begin
    pcnt_d = pcnt_q;
    if (clr) begin
      pcnt_d = '0;
    end else if (en) begin
      pcnt_d = (pcnt_q == LAST) ? '0 : pcnt_q + 1'b1;
    end
  end

  // Prescaler register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      pcnt_q <= '0;
    end else begin
      pcnt_q <= pcnt_d;
    end
  end

endmodule

// File: rtl/traffic_timer.sv
// Interval timer paired with the traffic-light controller.
// Counts prescaled ticks since the last start/clear pulse (sc) and decodes the
// short (ts) and long (tl) timeout levels from the registered count. The count
// saturates at TL_TICKS so both levels stay high until the next restart, which
// lets the controller wait in green for a car after tl.
// Edge priority: rst > sc > en. Outputs depend only on registers.
module traffic_timer
  import traffic_pkg::*;
#(
  parameter int CNT_W    = DEF_CNT_W,
  parameter int PRESCALE = DEF_PRESCALE,
  parameter int TS_TICKS = DEF_TS_TICKS,
  parameter int TL_TICKS = DEF_TL_TICKS
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sc,
  input  logic             en,
  output logic             ts,
  output logic             tl,
  output logic             tick,
  output logic [CNT_W-1:0] count
);

  if (TS_TICKS < 1) begin : g_bad_ts
    $error("traffic_timer: TS_TICKS must be at least 1");
  end
  if (TL_TICKS <= TS_TICKS) begin : g_bad_order
    $error("traffic_timer: TL_TICKS must exceed TS_TICKS");
  end
  if (TL_TICKS > (2 ** CNT_W) - 1) begin : g_bad_width
    $error("traffic_timer: TL_TICKS does not fit in CNT_W bits");
  end

  localparam logic [CNT_W-1:0] TS_C = CNT_W'(TS_TICKS);
  localparam logic [CNT_W-1:0] TL_C = CNT_W'(TL_TICKS);

  logic             tick_int;
  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;
  logic             tick_q;
  logic             tick_d;

  // sc doubles as the prescaler clear so a restart realigns the tick phase.
  tick_gen #(
    .PRESCALE(PRESCALE)
  ) u_tick_gen (
    .clk     (clk),
    .rst     (rst),
    .clr     (sc),
    .en      (en),
    .tick_int(tick_int)
  );

  // Next count and tick pulse: sc restarts, ticks advance up to saturation.
  always_comb begin
    count_d = count_q;
    tick_d  = 1'b0;
    if (sc) begin
      count_d = '0;
    end else if (tick_int) begin
      tick_d = 1'b1;
      if (count_q != TL_C) begin
        count_d = count_q + 1'b1;
      end
    end
  end

  // Counter and tick registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
      tick_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      tick_q  <= tick_d;
    end
  end

  // Timeout levels decode the registered count only.
  assign ts    = (count_q >= TS_C);
  assign tl    = (count_q >= TL_C);
  assign tick  = tick_q;
  assign count = count_q;

endmodule
